// File: rtl/seq_arbiter.sv
// Round-robin arbiter granting one of four serial requesters a FRAME_LEN-bit
// frame on a shared sequence detector. Define SEQ_ARB_ABORT_EN for early abort.
module seq_arbiter #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [3:0]       bit_in,
  output logic [3:0]       grant,
  output logic             det_clr,
  output logic             det_x,
  input  logic             det_out,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             done,
  output logic [1:0]       done_id,
  output logic             aborted
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t           state_reg, state_next;
  logic [1:0]       winner_reg, winner_next;
  logic [1:0]       last_winner_reg, last_winner_next;
  logic [7:0]       bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0] hit_cnt_reg, hit_cnt_next;
  logic [1:0]       rr_pick;
  logic             count_en;
  logic             abort_now;

  // Lowest offset from last_winner+1 wins; scanning downward lets it overwrite.
  always_comb begin
    rr_pick = last_winner_reg + 2'd1;
    for (int i = 4; i >= 1; i--) begin
      if (req[2'(last_winner_reg + 2'(i))]) begin
        rr_pick = last_winner_reg + 2'(i);
      end
    end
  end

  // det_out lags det_x by one cycle, so the first STREAM cycle carries no sample.
  assign count_en = det_out &&
                    (((state_reg == STREAM) && (bit_cnt_reg != 8'd0)) ||
                     (state_reg == DRAIN));

`ifdef SEQ_ARB_ABORT_EN
  logic aborted_reg, aborted_next;

  assign abort_now = (state_reg == STREAM) && !req[winner_reg];

  always_comb begin
    aborted_next = aborted_reg;
    if (state_reg == CLEAR) begin
      aborted_next = 1'b0;
    end else if (abort_now) begin
      aborted_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aborted_reg <= 1'b0;
    end else begin
      aborted_reg <= aborted_next;
    end
  end

  assign aborted = (state_reg == DONE) && aborted_reg;
`else
  assign abort_now = 1'b0;
  assign aborted   = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    winner_next      = winner_reg;
    last_winner_next = last_winner_reg;
    bit_cnt_next     = bit_cnt_reg;
    hit_cnt_next     = hit_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          winner_next  = rr_pick;
          hit_cnt_next = '0;
          state_next   = CLEAR;
        end
      end
      CLEAR: begin
        hit_cnt_next = '0;
        bit_cnt_next = 8'd0;
        state_next   = STREAM;
      end
      STREAM: begin
        bit_cnt_next = bit_cnt_reg + 8'd1;
        if ((bit_cnt_reg == LAST_IDX) || abort_now) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = DONE;
      end
      DONE: begin
        last_winner_next = winner_reg;
        state_next       = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (count_en && (hit_cnt_reg != '1)) begin
      hit_cnt_next = hit_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      winner_reg      <= 2'd0;
      last_winner_reg <= 2'd3;
      bit_cnt_reg     <= 8'd0;
      hit_cnt_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      winner_reg      <= winner_next;
      last_winner_reg <= last_winner_next;
      bit_cnt_reg     <= bit_cnt_next;
      hit_cnt_reg     <= hit_cnt_next;
    end
  end

  // Outputs decode straight from state so reset drops them without a clock.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_grant
      assign grant[gi] = (state_reg == STREAM) && (winner_reg == 2'(gi));
    end
  endgenerate

  assign det_x   = (state_reg == STREAM) ? bit_in[winner_reg] : 1'b0;
  assign det_clr = (state_reg == CLEAR);
  assign done    = (state_reg == DONE);
  assign done_id = (state_reg == DONE) ? winner_reg : 2'd0;
  assign hit_cnt = hit_cnt_reg;

endmodule

// File: tb/tb_seq_arbiter.sv
// Scoreboard bench for seq_arbiter: a default instance plus a CNT_W=2 instance
// sharing the same stimulus to exercise hit_cnt saturation.
`timescale 1ns/1ps
module tb_seq_arbiter;

  localparam int FL = 8;

  typedef struct {
    int         id;
    int         hit;
    int         sat;
    int         ab;
    int         n;
    logic [7:0] bits;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] bit_in = 4'b0;
  logic       det_out;
  logic [3:0] grant;
  logic       det_clr, det_x, done, aborted;
  logic [7:0] hit_cnt;
  logic [1:0] done_id;
  logic [3:0] s_grant;
  logic       s_det_clr, s_det_x, s_done, s_aborted;
  logic [1:0] s_hit_cnt;
  logic [1:0] s_done_id;
  logic       det_q = 1'b0;
  int         det_mode = 0;

  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         cyc = 0;
  int         last_hit = 0;
  logic [7:0] pat [4];
  int         cons_idx [4];
  int         model_idx [4];
  exp_t       sb [$];
  int         starts [$];
  int         start_ids [$];

  always #5 clk = ~clk;

  seq_arbiter #(.FRAME_LEN(FL), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .grant(grant),
    .det_clr(det_clr), .det_x(det_x), .det_out(det_out), .hit_cnt(hit_cnt),
    .done(done), .done_id(done_id), .aborted(aborted)
  );

  seq_arbiter #(.FRAME_LEN(FL), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .grant(s_grant),
    .det_clr(s_det_clr), .det_x(s_det_x), .det_out(det_out), .hit_cnt(s_hit_cnt),
    .done(s_done), .done_id(s_done_id), .aborted(s_aborted)
  );

  // Detector stand-in: either a constant or det_x delayed by one cycle.
  always_ff @(posedge clk) det_q <= det_x;
  assign det_out = (det_mode == 0) ? 1'b1 : (det_mode == 1) ? 1'b0 : det_q;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] g);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic drive_bits();
    for (int l = 0; l < 4; l++) bit_in[l] = pat[l][cons_idx[l] % 8];
  endtask

  task automatic clear_idx();
    for (int l = 0; l < 4; l++) begin
      cons_idx[l]  = 0;
      model_idx[l] = 0;
    end
    drive_bits();
  endtask

  // A source consumes one bit for every cycle its grant was high.
  task automatic tick();
    logic [3:0] g;
    g = grant;
    @(posedge clk);
    #1;
    for (int l = 0; l < 4; l++) if (g[l]) cons_idx[l]++;
    drive_bits();
  endtask

  task automatic push_frame(input int id, input int n, input int ab);
    exp_t e;
    int   ones;
    e.id = id; e.n = n; e.ab = ab; e.bits = 8'h00; ones = 0;
    for (int k = 0; k < n; k++) begin
      e.bits[k] = pat[id][(model_idx[id] + k) % 8];
      ones += int'(e.bits[k]);
    end
    case (det_mode)
      0:       e.hit = n;
      1:       e.hit = 0;
      default: e.hit = ones;
    endcase
    e.sat = (e.hit > 3) ? 3 : e.hit;
    model_idx[id] += n;
    sb.push_back(e);
  endtask

  task automatic run_until(input int target, input int budget);
    int t;
    t = 0;
    while (done_cnt < target && t < budget) begin
      tick();
      t++;
    end
    if (done_cnt < target) chk("timeout_done", done_cnt, target);
  endtask

  task automatic wait_grant(input int lane, input int cycles);
    int gc;
    int t;
    gc = 0;
    t = 0;
    while (gc < cycles && t < 40) begin
      tick();
      t++;
      if (grant[lane]) gc++;
    end
    if (gc < cycles) chk("timeout_grant", gc, cycles);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_det_clr"}, det_clr, 0);
    chk({tag, "_det_x"}, det_x, 0);
    chk({tag, "_hit_cnt"}, hit_cnt, 0);
    chk({tag, "_sat_hit_cnt"}, s_hit_cnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_done_id"}, done_id, 0);
    chk({tag, "_aborted"}, aborted, 0);
  endtask

  // Output monitor: collects each frame and pops the scoreboard on done.
  initial begin
    exp_t       e;
    int         act_n, clr_n, s_gn, s_clr_n;
    logic [7:0] act_bits;
    logic [3:0] prev_grant;
    act_n = 0; clr_n = 0; s_gn = 0; s_clr_n = 0; act_bits = 8'h00; prev_grant = 4'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        act_n = 0; clr_n = 0; s_gn = 0; s_clr_n = 0; act_bits = 8'h00;
      end else begin
        if (det_clr) clr_n++;
        if (s_det_clr) s_clr_n++;
        if (s_grant != 4'b0) s_gn++;
        else chk("sat_det_x_idle", s_det_x, 0);
        if (grant != 4'b0) begin
          if (prev_grant == 4'b0) begin
            starts.push_back(cyc);
            start_ids.push_back(onehot_idx(grant));
          end
          chk("grant_onehot", $countones(grant), 1);
          if (act_n < 8) act_bits[act_n] = det_x;
          act_n++;
        end else begin
          chk("det_x_idle", det_x, 0);
        end
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", done, 0);
          end else begin
            e = sb.pop_front();
            chk("done_id", done_id, e.id);
            chk("hit_cnt", hit_cnt, e.hit);
            chk("sat_hit_cnt", s_hit_cnt, e.sat);
            chk("aborted", aborted, e.ab);
            chk("stream_len", act_n, e.n);
            chk("det_x_bits", act_bits, e.bits);
            chk("det_clr_pulses", clr_n, 1);
            chk("sat_done", s_done, 1);
            chk("sat_done_id", s_done_id, e.id);
            chk("sat_aborted", s_aborted, e.ab);
            chk("sat_stream_len", s_gn, e.n);
            chk("sat_det_clr_pulses", s_clr_n, 1);
            $display("frame id=%0d bits=%0d hit=%0d sat=%0d aborted=%0d", e.id, e.n, e.hit, e.sat, e.ab);
            last_hit = e.hit;
          end
          done_cnt++;
          act_n = 0; clr_n = 0; s_gn = 0; s_clr_n = 0; act_bits = 8'h00;
        end else begin
          chk("aborted_outside_done", aborted, 0);
        end
      end
      prev_grant = reset ? grant : 4'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    pat[0] = 8'hA5;
    pat[1] = 8'b0100_1101;
    pat[2] = 8'h3C;
    pat[3] = 8'h96;
    clear_idx();

    // Reset state, then single requester with det_out tied high.
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst0");
    reset = 1'b1;
    req = 4'b0001;
    det_mode = 0;
    push_frame(0, FL, 0);
    run_until(1, 40);
    req = 4'b0000;
    tick();
    chk("hit_hold", hit_cnt, last_hit);
    chk("idle_grant", grant, 0);

    // Fresh reset, all four requesting: rotation 0,1,2,3,0 every 12 cycles.
    reset = 1'b0;
    tick();
    reset_checks("rst1");
    clear_idx();
    reset = 1'b1;
    starts.delete();
    start_ids.delete();
    base = done_cnt;
    req = 4'b1111;
    det_mode = 2;
    push_frame(0, FL, 0);
    push_frame(1, FL, 0);
    push_frame(2, FL, 0);
    push_frame(3, FL, 0);
    push_frame(0, FL, 0);
    run_until(base + 5, 100);
    req = 4'b0000;
    tick();
    chk("rr_start_count", starts.size(), 5);
    if (starts.size() == 5) begin
      chk("rr_id0", start_ids[0], 0);
      chk("rr_id1", start_ids[1], 1);
      chk("rr_id2", start_ids[2], 2);
      chk("rr_id3", start_ids[3], 3);
      chk("rr_id4", start_ids[4], 0);
      for (int i = 1; i < 5; i++) chk("grant_spacing", starts[i] - starts[i-1], FL + 4);
    end

    // det_out tied low gives zero hits.
    base = done_cnt;
    det_mode = 1;
    req = 4'b0100;
    push_frame(2, FL, 0);
    run_until(base + 1, 40);
    req = 4'b0000;
    tick();
    chk("hit_hold_zero", hit_cnt, last_hit);

    // Request drop in the third STREAM cycle.
    base = done_cnt;
    det_mode = 0;
    req = 4'b0100;
`ifdef SEQ_ARB_ABORT_EN
    push_frame(2, 3, 1);
`else
    push_frame(2, FL, 0);
`endif
    wait_grant(2, 3);
    req = 4'b0000;
    run_until(base + 1, 40);
    tick();

    // Reset in STREAM cycle 5 kills the frame without a done pulse.
    base = done_cnt;
    det_mode = 0;
    req = 4'b0001;
    wait_grant(0, 5);
    reset = 1'b0;
    #1;
    chk("async_grant_drop", grant, 0);
    tick();
    tick();
    reset_checks("rst2");
    chk("no_done_on_reset", done_cnt, base);
    chk("sb_empty_after_kill", sb.size(), 0);
    clear_idx();
    reset = 1'b1;

    // Requester 1 after reset streams its pattern through det_x.
    req = 4'b0010;
    det_mode = 2;
    push_frame(1, FL, 0);
    run_until(base + 1, 40);
    req = 4'b0000;
    tick();
    chk("hit_hold_final", hit_cnt, last_hit);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
